fft_frame_ctrl: RTL

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

---
 rtl/fft_frame_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for a streaming FFT stage: loads N samples into the sample
// buffer, issues N datapath reads, waits for the LAT-deep pipeline to empty,
// then pulses frame_done.
//   clk, rst     : clock, synchronous active-high reset
//   start        : frame-start request (honoured only in IDLE)
//   in_valid     : upstream sample valid; in_ready is high in LOAD
//   wr_en/wr_addr: sample buffer write strobe/address
//   rd_en/rd_addr: datapath issue strobe/read address
//   out_valid    : rd_en delayed LAT cycles
//   frame_done   : one-cycle end-of-frame pulse
//   busy         : high outside IDLE
//   overrun      : sticky, set when start arrives outside IDLE
module fft_frame_ctrl #(
  parameter int unsigned N     = 128,
  parameter int unsigned LOG2N = 7,
  parameter int unsigned LAT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr,
  output logic             out_valid,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun
);

  localparam logic [LOG2N-1:0] LAST_ADDR = LOG2N'(N - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] rd_cnt;
  logic [LAT-1:0]   vld_sr;
  logic             overrun_q;
  logic             accept;
  logic             in_run;

  assign accept = in_valid & (state == LOAD);
  assign in_run = (state == RUN);

  // State, counters, valid pipeline and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      vld_sr    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) wr_cnt <= wr_cnt + LOG2N'(1);
      if (in_run) rd_cnt <= rd_cnt + LOG2N'(1);
      // Shift-left form keeps LAT=1 legal (no [LAT-2:0] slice)
      vld_sr <= (vld_sr << 1) | LAT'(in_run);
      if (start && (state != IDLE)) overrun_q <= 1'b1;
    end
  end

  // Next state and output decode; rst masks outputs in the same cycle
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    out_valid  = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b0;
    overrun    = 1'b0;

    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (accept && (wr_cnt == LAST_ADDR)) state_nxt = RUN;
      RUN:     if (rd_cnt == LAST_ADDR) state_nxt = DRAIN;
      // The pipeline empties the cycle after the last out_valid
      DRAIN:   if (vld_sr == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (!rst) begin
      in_ready   = (state == LOAD);
      wr_en      = accept;
      wr_addr    = wr_cnt;
      rd_en      = in_run;
      rd_addr    = rd_cnt;
      out_valid  = vld_sr[LAT-1];
      frame_done = (state == DONE);
      busy       = (state != IDLE);
      overrun    = overrun_q;
    end
  end

endmodule
